// File: rtl/lmc_loader_if.sv
// Program-word stream between a source (master) and the loader (slave).
// Signals: data_in (M), data_valid (source->loader), data_ready (loader->source).
interface lmc_loader_if #(
  parameter int M = 4
);
  logic [M-1:0] data_in;
  logic         data_valid;
  logic         data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/lmc_loader.sv
// LMC program loader: streams 2**N words into RAM, reads them back and
// checks a mod-2**M checksum before reporting done or error.
// Ports: Loader_clk, Loader_rst (async, active-high), start,
//   src (stream slave: data_in/data_valid/data_ready),
//   adr, RAM_wdata, RAM_we, RAM_rdata (RAM bus), busy, done, error.
// Option: define LOADER_TIMEOUT_EN to add parameter TIMEOUT; LOAD then
//   aborts to ERROR after TIMEOUT consecutive cycles without data_valid.
module lmc_loader #(
  parameter int N = 2,
  parameter int M = 4
`ifdef LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic         Loader_clk,
  input  logic         Loader_rst,
  input  logic         start,
  lmc_loader_if.slave  src,
  output logic [N-1:0] adr,
  output logic [M-1:0] RAM_wdata,
  output logic         RAM_we,
  input  logic [M-1:0] RAM_rdata,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    VERIFY,
    DONE,
    ERROR
  } state_t;

  state_t       state, state_n;
  logic [N-1:0] adr_n;
  logic [M-1:0] wdata_n;
  logic         we_n;
  logic         done_n, error_n;
  logic [N-1:0] wcount, wcount_n;
  logic [N:0]   vcount, vcount_n;
  logic [M-1:0] wsum, wsum_n;
  logic [M-1:0] vsum, vsum_n;
  logic         accept;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt, tcnt_n;
`endif

  assign src.data_ready = (state == LOAD);
  assign busy = (state == LOAD) || (state == DRAIN)
             || (state == VERIFY);
  assign accept = src.data_valid && src.data_ready;

  always_ff @(posedge Loader_clk or posedge Loader_rst) begin
    if (Loader_rst) begin
      state     <= IDLE;
      adr       <= '0;
      RAM_wdata <= '0;
      RAM_we    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      wcount    <= '0;
      vcount    <= '0;
      wsum      <= '0;
      vsum      <= '0;
`ifdef LOADER_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      state     <= state_n;
      adr       <= adr_n;
      RAM_wdata <= wdata_n;
      RAM_we    <= we_n;
      done      <= done_n;
      error     <= error_n;
      wcount    <= wcount_n;
      vcount    <= vcount_n;
      wsum      <= wsum_n;
      vsum      <= vsum_n;
`ifdef LOADER_TIMEOUT_EN
      tcnt      <= tcnt_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    adr_n    = adr;
    wdata_n  = RAM_wdata;
    we_n     = 1'b0;
    done_n   = done;
    error_n  = error;
    wcount_n = wcount;
    vcount_n = vcount;
    wsum_n   = wsum;
    vsum_n   = vsum;
`ifdef LOADER_TIMEOUT_EN
    tcnt_n   = tcnt;
`endif
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_n  = LOAD;
          done_n   = 1'b0;
          error_n  = 1'b0;
          wcount_n = '0;
          vcount_n = '0;
          wsum_n   = '0;
          vsum_n   = '0;
`ifdef LOADER_TIMEOUT_EN
          tcnt_n   = '0;
`endif
        end
      end
      LOAD: begin
        if (accept) begin
          wdata_n  = src.data_in;
          adr_n    = wcount;
          we_n     = 1'b1;
          wsum_n   = wsum + src.data_in;
          wcount_n = wcount + 1'b1;
`ifdef LOADER_TIMEOUT_EN
          tcnt_n   = '0;
`endif
          if (wcount == '1)
            state_n = DRAIN;
        end
`ifdef LOADER_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT - 1)) begin
          state_n = ERROR;
          error_n = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
`endif
      end
      DRAIN: begin
        state_n = VERIFY;
        adr_n   = '0;
      end
      VERIFY: begin
        // 2**N read cycles, then one cycle (adr wrapped to 0)
        // to compare the settled vsum against wsum.
        if (vcount[N]) begin
          if (vsum == wsum) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ERROR;
            error_n = 1'b1;
          end
        end else begin
          vsum_n   = vsum + RAM_rdata;
          adr_n    = adr + 1'b1;
          vcount_n = vcount + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lmc_loader.sv
// Randomized self-checking bench for lmc_loader with a RAM model and
// a checksum/ordering reference computed from the loaded word list.
module tb_lmc_loader;
  localparam int N = 2;
  localparam int M = 4;
  localparam int D = 1 << N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] adr;
  logic [M-1:0] ram_wdata;
  logic         ram_we;
  logic [M-1:0] ram_rdata;
  logic         busy, done, error;

  lmc_loader_if #(.M(M)) src_if ();

  lmc_loader #(.N(N), .M(M)) dut (
    .Loader_clk (clk),
    .Loader_rst (rst),
    .start      (start),
    .src        (src_if.slave),
    .adr        (adr),
    .RAM_wdata  (ram_wdata),
    .RAM_we     (ram_we),
    .RAM_rdata  (ram_rdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  logic [M-1:0] ram [D];
  logic [7:0]   wr_q [$];
  logic [M-1:0] words [D];
  bit           pat [$];
  int           bad_adr = -1;
  logic [M-1:0] bad_val = '0;
  int           errors = 0;
  int           checks = 0;

  assign ram_rdata = (bad_adr == int'(adr)) ? bad_val : ram[adr];

  always @(posedge clk) begin
    if (ram_we) begin
      ram[adr] <= ram_wdata;
      wr_q.push_back({2'b00, adr, ram_wdata});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_adr"}, 32'(adr), 0);
    check({tag, "_wdata"}, 32'(ram_wdata), 0);
    check({tag, "_we"}, 32'(ram_we), 0);
    check({tag, "_ready"}, 32'(src_if.data_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
  endtask

  // One complete load of words[]; valid follows pat[] then density %.
  task automatic load_run(input int density, input bit poke);
    int idx, cyc, n, sw, sr;
    bit v, ok;
    wr_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_load", 32'(busy), 1);
    check("done_clr", 32'(done), 0);
    check("err_clr", 32'(error), 0);
    check("ready_load", 32'(src_if.data_ready), 1);
    idx = 0;
    cyc = 0;
    while (idx < D && cyc < 400) begin
      if (pat.size() > 0) v = pat.pop_front();
      else v = ($urandom_range(99) < density);
      src_if.data_valid = v;
      src_if.data_in = v ? words[idx] : M'($urandom);
      start = poke && ($urandom_range(3) == 0);
      tick();
      cyc++;
      if (v) idx++;
    end
    check("accepts", 32'(idx), D);
    src_if.data_valid = 1'b0;
    src_if.data_in = M'($urandom);
    start = 1'b0;
    n = 0;
    while (!(done || error) && n < 40) begin
      start = poke && (n < 4);
      tick();
      n++;
    end
    start = 1'b0;
    sw = 0;
    sr = 0;
    for (int i = 0; i < D; i++) begin
      sw += int'(words[i]);
      sr += (i == bad_adr) ? int'(bad_val) : int'(words[i]);
    end
    ok = ((sw % (1 << M)) == (sr % (1 << M)));
    check("latency", 32'(n), D + 2);
    check("done", 32'(done), 32'(ok));
    check("error", 32'(error), 32'(!ok));
    check("busy_end", 32'(busy), 0);
    check("n_writes", 32'(wr_q.size()), D);
    for (int i = 0; i < D && i < wr_q.size(); i++) begin
      check("wr_adr", 32'(wr_q[i][7:4]), i);
      check("wr_data", 32'(wr_q[i][3:0]), 32'(words[i]));
    end
    bad_adr = -1;
  endtask

  initial begin
    src_if.data_valid = 1'b0;
    src_if.data_in = '0;
    for (int i = 0; i < D; i++) ram[i] = '0;
    repeat (2) tick();
    check_idle("rst");
    rst = 1'b0;
    tick();
    check_idle("idle");

    words = '{4'h3, 4'h5, 4'h9, 4'hF};
    load_run(100, 1'b0);

    words = '{4'h3, 4'h5, 4'h9, 4'hF};
    bad_adr = 2;
    bad_val = 4'h8;
    load_run(100, 1'b0);

    words = '{4'hA, 4'hB, 4'hC, 4'hD};
    pat = '{1, 0, 0, 1, 1, 0, 1};
    load_run(100, 1'b0);

    for (int i = 0; i < D; i++) words[i] = M'($urandom);
    load_run(60, 1'b1);
    check("ready_done", 32'(src_if.data_ready), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    src_if.data_valid = 1'b1;
    src_if.data_in = 4'h1;
    tick();
    src_if.data_in = 4'h2;
    tick();
    src_if.data_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_idle("midrst");
    tick();
    rst = 1'b0;
    tick();
    check_idle("postrst");
    for (int i = 0; i < D; i++) words[i] = M'($urandom);
    load_run(80, 1'b0);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < D; i++) words[i] = M'($urandom);
      if ($urandom_range(1) == 1) begin
        bad_adr = $urandom_range(D - 1);
        bad_val = M'($urandom);
      end
      load_run($urandom_range(90, 20), k[0]);
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    src_if.data_valid = 1'b1;
    src_if.data_in = 4'h7;
    tick();
    src_if.data_valid = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    repeat (15) tick();
    check("to_busy", 32'(busy), 1);
    check("to_err_early", 32'(error), 0);
    tick();
    check("to_error", 32'(error), 1);
    check("to_busy_end", 32'(busy), 0);
    check("to_we", 32'(ram_we), 0);
    check("to_done", 32'(done), 0);
`else
    repeat (100) tick();
    check("wait_busy", 32'(busy), 1);
    check("wait_ready", 32'(src_if.data_ready), 1);
    check("wait_error", 32'(error), 0);
    check("wait_done", 32'(done), 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
